dmem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the single-port data memory.
- Port m0 is the CPU load/store path. Port m1 is a secondary master (program loader / debug / DMA).
- Grants one transaction at a time with round-robin priority, drives the memory for one issue cycle, waits a fixed read latency, then returns a single-cycle response to the owner.

---
 rtl/dmem_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter and sequencer for the single-port data memory.
// Optional conflict counter output is enabled by defining DMEM_ARB_PERF_EN.
module dmem_arbiter #(
  parameter int READ_LAT = 1,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_req_valid,
  output logic              m0_req_ready,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [2:0]        m0_funct3,
  output logic              m0_rsp_valid,
  output logic [DATA_W-1:0] m0_rdata,

  input  logic              m1_req_valid,
  output logic              m1_req_ready,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [2:0]        m1_funct3,
  output logic              m1_rsp_valid,
  output logic [DATA_W-1:0] m1_rdata,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_funct3,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              busy
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [15:0]       conflict_cnt
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic [3:0] CNT_INIT = 4'(READ_LAT - 1);

  logic [1:0]        state_q,      state_d;
  logic [3:0]        cnt_q,        cnt_d;
  logic              owner_q,      owner_d;
  logic              last_grant_q, last_grant_d;
  logic              we_q,         we_d;
  logic [ADDR_W-1:0] addr_q,       addr_d;
  logic [DATA_W-1:0] wdata_q,      wdata_d;
  logic [2:0]        funct3_q,     funct3_d;
  logic [DATA_W-1:0] m0_rdata_q,   m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q,   m1_rdata_d;

  logic in_idle;
  logic grant0;
  logic grant1;
  logic accept;
  logic in_issue;
  logic in_resp;

  // Ready is withheld while reset is asserted so every output reads 0 during reset.
  assign in_idle = (state_q == ST_IDLE) && rst;

  // On contention the requester that did not win last time gets the slot.
  assign grant0 = in_idle && m0_req_valid && (!m1_req_valid ||  last_grant_q);
  assign grant1 = in_idle && m1_req_valid && (!m0_req_valid || !last_grant_q);
  assign accept = grant0 || grant1;

  assign m0_req_ready = grant0;
  assign m1_req_ready = grant1;

  always_comb begin
    // NOTE: every next-state variable gets its hold value first so no path can infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    funct3_d     = funct3_q;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          owner_d      = grant1;
          last_grant_d = grant1;
          we_d         = grant1 ? m1_we     : m0_we;
          addr_d       = grant1 ? m1_addr   : m0_addr;
          wdata_d      = grant1 ? m1_wdata  : m0_wdata;
          funct3_d     = grant1 ? m1_funct3 : m0_funct3;
          state_d      = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (we_q) begin
          // A store acknowledges with zero data.
          if (owner_q) m1_rdata_d = '0;
          else         m0_rdata_d = '0;
          state_d = ST_RESP;
        end else begin
          cnt_d   = CNT_INIT;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          if (owner_q) m1_rdata_d = mem_rdata;
          else         m0_rdata_d = mem_rdata;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_RESP: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      funct3_q     <= 3'd0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      // NOTE: non-blocking updates so all state registers sample the same pre-edge values.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      funct3_q     <= funct3_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

  assign in_issue = (state_q == ST_ISSUE);
  assign in_resp  = (state_q == ST_RESP);

  // Memory-side buses are forced to zero outside the issue cycle.
  assign mem_en     = in_issue;
  assign mem_we     = in_issue && we_q;
  assign mem_addr   = in_issue ? addr_q   : '0;
  assign mem_wdata  = in_issue ? wdata_q  : '0;
  assign mem_funct3 = in_issue ? funct3_q : 3'd0;

  assign m0_rsp_valid = in_resp && !owner_q;
  assign m1_rsp_valid = in_resp &&  owner_q;
  assign m0_rdata     = m0_rdata_q;
  assign m1_rdata     = m1_rdata_q;

  assign busy = (state_q != ST_IDLE);

`ifdef DMEM_ARB_PERF_EN
  logic        both_valid;
  logic [15:0] conflict_q, conflict_d;

  assign both_valid = m0_req_valid && m1_req_valid;

  always_comb begin
    conflict_d = conflict_q;
    if (accept && both_valid && (conflict_q != 16'hFFFF)) conflict_d = conflict_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) conflict_q <= 16'd0;
    else      conflict_q <= conflict_d;
  end

  assign conflict_cnt = conflict_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector tables, multi-cycle sequences,
// and a randomized run scored against a transaction-level model of the arbiter.
module tb_dmem_arbiter;

  localparam int READ_LAT = 3;
  localparam int LOAD_LAT = READ_LAT + 2;
  localparam int STORE_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req_valid, m0_req_ready, m0_we, m0_rsp_valid;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [2:0]  m0_funct3;
  logic        m1_req_valid, m1_req_ready, m1_we, m1_rsp_valid;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [2:0]  m1_funct3;
  logic        mem_en, mem_we, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_funct3;
`ifdef DMEM_ARB_PERF_EN
  logic [15:0] conflict_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.READ_LAT(READ_LAT), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_we(m0_we),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_funct3(m0_funct3),
    .m0_rsp_valid(m0_rsp_valid), .m0_rdata(m0_rdata),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_we(m1_we),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_funct3(m1_funct3),
    .m1_rsp_valid(m1_rsp_valid), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_funct3(mem_funct3), .mem_rdata(mem_rdata),
    .busy(busy)
`ifdef DMEM_ARB_PERF_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  // Memory device: word array plus a READ_LAT-deep read pipe; junk appears outside the load slot.
  logic        mem_clear;
  logic [31:0] dev_mem [0:255];
  logic [31:0] rd_pipe [0:READ_LAT-1];

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) dev_mem[i] <= 32'd0;
    end else if (mem_en && mem_we) begin
      dev_mem[mem_addr[9:2]] <= mem_wdata;
    end
    rd_pipe[0] <= (mem_en && !mem_we) ? dev_mem[mem_addr[9:2]] : $urandom;
    for (int k = 1; k < READ_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign mem_rdata = rd_pipe[READ_LAT-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int p, input logic v, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] f);
    if (p == 0) begin
      m0_req_valid = v; m0_we = we; m0_addr = a; m0_wdata = d; m0_funct3 = f;
    end else begin
      m1_req_valid = v; m1_we = we; m1_addr = a; m1_wdata = d; m1_funct3 = f;
    end
  endtask

  function automatic logic rdy(input int p);
    return (p == 0) ? m0_req_ready : m1_req_ready;
  endfunction
  function automatic logic rspv(input int p);
    return (p == 0) ? m0_rsp_valid : m1_rsp_valid;
  endfunction
  function automatic logic [31:0] rdat(input int p);
    return (p == 0) ? m0_rdata : m1_rdata;
  endfunction
  function automatic logic vld(input int p);
    return (p == 0) ? m0_req_valid : m1_req_valid;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    mem_clear = 1'b1;
    set_req(0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    set_req(1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    mem_clear = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (!busy) begin ok = 1; break; end
    end
    check({nm, "_drain"}, ok, 1'b1);
  endtask

  // One request from port p; checks accept, issue-cycle memory bus, response latency and data.
  task automatic do_txn(input int p, input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] f, input int exp_lat, input logic [31:0] exp_rd,
                        input string nm);
    bit got;
    int lat, stray, extra_en;
    got = 0; lat = 0; stray = 0; extra_en = 0;
    @(negedge clk);
    set_req(p, 1'b1, we, a, d, f);
    #1;
    for (int k = 0; k < 40; k++) begin
      if (rdy(p)) begin got = 1; break; end
      @(negedge clk); #1;
    end
    check({nm, "_accept"}, got, 1'b1);
    if (!got) begin
      set_req(p, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
      return;
    end
    check({nm, "_other_ready"}, rdy(1 - p), 1'b0);
    @(negedge clk);
    set_req(p, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    #1;
    check({nm, "_mem_en"},     mem_en, 1'b1);
    check({nm, "_mem_we"},     mem_we, we);
    check({nm, "_mem_addr"},   mem_addr, a);
    check({nm, "_mem_wdata"},  mem_wdata, d);
    check({nm, "_mem_funct3"}, mem_funct3, f);
    check({nm, "_busy"},       busy, 1'b1);
    for (int c = 2; c < 40; c++) begin
      @(negedge clk); #1;
      if (rspv(1 - p)) stray++;
      if (mem_en) extra_en++;
      if (rspv(p)) begin lat = c; break; end
    end
    check({nm, "_latency"},   lat, exp_lat);
    check({nm, "_rdata"},     rdat(p), exp_rd);
    check({nm, "_other_rsp"}, stray, 0);
    check({nm, "_extra_en"},  extra_en, 0);
    @(negedge clk); #1;
    check({nm, "_rsp_pulse"}, rspv(p), 1'b0);
    check({nm, "_rdata_hold"}, rdat(p), exp_rd);
    check({nm, "_back_idle"}, busy, 1'b0);
  endtask

  // Both requesters held valid with fresh stores after every grant; records grant order.
  int cont_owner [0:7];
  int cont_cyc   [0:7];
  int cont_n;

  task automatic run_contended(input int n_grants);
    bit prev0, prev1, a0, a1;
    cont_n = 0;
    prev0 = 1; prev1 = 1;
    @(negedge clk);
    for (int c = 0; c < 100 && cont_n < n_grants; c++) begin
      if (c > 0) @(negedge clk);
      if (prev0) set_req(0, 1'b1, 1'b1, 32'h300 + 32'(c * 4), 32'hA000_0000 + 32'(c), 3'b010);
      if (prev1) set_req(1, 1'b1, 1'b1, 32'h380 + 32'(c * 4), 32'hB000_0000 + 32'(c), 3'b010);
      #1;
      a0 = m0_req_valid && m0_req_ready;
      a1 = m1_req_valid && m1_req_ready;
      if (a0 && cont_n < 8) begin cont_owner[cont_n] = 0; cont_cyc[cont_n] = c; cont_n++; end
      if (a1 && cont_n < 8) begin cont_owner[cont_n] = 1; cont_cyc[cont_n] = c; cont_n++; end
      prev0 = a0; prev1 = a1;
    end
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    set_req(1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    wait_idle("contend");
  endtask

  // Transaction-level reference: a slot is free once the previous response has gone out,
  // contention goes to whoever did not win last, and loads return the latest stored word.
  typedef struct {
    int          port;
    int          cyc;
    logic [31:0] rdata;
  } rsp_t;

  task automatic run_random(input int ncyc);
    logic [31:0] model_mem [0:255];
    logic [31:0] last_rd [0:1];
    rsp_t        q[$];
    rsp_t        e;
    int          acc_cyc, busy_until, last_owner, owner, idx;
    bit          acc_prev [0:1];
    bit          a0, a1, v0, v1, exp0, exp1;
    logic        owe;
    logic [31:0] oaddr, odata;
    for (int i = 0; i < 256; i++) model_mem[i] = 32'd0;
    last_rd[0] = 32'd0; last_rd[1] = 32'd0;
    acc_prev[0] = 0; acc_prev[1] = 0;
    acc_cyc = -10; busy_until = -10; last_owner = 1;
    for (int cyc = 0; cyc < ncyc + 14; cyc++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (cyc >= ncyc) begin
          set_req(p, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        end else if (!vld(p) || acc_prev[p]) begin
          idx = int'($urandom_range(15));
          set_req(p, 1'($urandom_range(2) != 0), 1'($urandom_range(1)),
                  32'h1000 + 32'(idx * 4), $urandom, 3'($urandom_range(7)));
        end
      end
      #1;
      v0 = m0_req_valid; v1 = m1_req_valid;
      a0 = v0 && m0_req_ready;
      a1 = v1 && m1_req_ready;
      check("rand_ready_any", m0_req_ready || m1_req_ready, (cyc > busy_until) && (v0 || v1));
      check("rand_ready_both", m0_req_ready && m1_req_ready, 1'b0);
      if (a0 || a1) begin
        owner = a1 ? 1 : 0;
        if (v0 && v1) check("rand_rr_owner", owner, 1 - last_owner);
        last_owner = owner;
        owe   = owner ? m1_we : m0_we;
        oaddr = owner ? m1_addr : m0_addr;
        odata = owner ? m1_wdata : m0_wdata;
        acc_cyc = cyc;
        busy_until = cyc + (owe ? STORE_LAT : LOAD_LAT);
        e.port = owner; e.cyc = busy_until;
        e.rdata = owe ? 32'd0 : model_mem[oaddr[9:2]];
        if (owe) model_mem[oaddr[9:2]] = odata;
        q.push_back(e);
      end
      check("rand_busy", busy, (cyc > acc_cyc) && (cyc <= busy_until));
      check("rand_mem_en", mem_en, cyc == acc_cyc + 1);
      if (!mem_en) check("rand_mem_idle_zero", {mem_we, mem_addr, mem_wdata, mem_funct3}, 68'd0);
      exp0 = 0; exp1 = 0;
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        if (e.port == 0) exp0 = 1; else exp1 = 1;
        last_rd[e.port] = e.rdata;
      end
      check("rand_m0_rsp", m0_rsp_valid, exp0);
      check("rand_m1_rsp", m1_rsp_valid, exp1);
      check("rand_m0_rdata", m0_rdata, last_rd[0]);
      check("rand_m1_rdata", m1_rdata, last_rd[1]);
      acc_prev[0] = a0; acc_prev[1] = a1;
    end
    check("rand_all_responded", q.size(), 0);
  endtask

  typedef struct {
    logic m0_v;
    logic m1_v;
    logic exp_r0;
    logic exp_r1;
  } arb_vec_t;

  typedef struct {
    int          port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    int          lat;
    logic [31:0] rdata;
  } txn_vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    arb_vec_t arb_tbl [0:3];
    txn_vec_t txn_tbl [0:7];
    int n_early, k, n_rsp, n_busy;

    arb_tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    arb_tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0};
    arb_tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1};
    arb_tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0};

    txn_tbl[0] = '{0, 1'b1, 32'h100, 32'hDEADBEEF, 3'b010, STORE_LAT, 32'h0};
    txn_tbl[1] = '{1, 1'b0, 32'h100, 32'h0000_0011, 3'b010, LOAD_LAT, 32'hDEADBEEF};
    txn_tbl[2] = '{1, 1'b1, 32'h200, 32'h12345678, 3'b010, STORE_LAT, 32'h0};
    txn_tbl[3] = '{1, 1'b0, 32'h200, 32'h0000_0022, 3'b010, LOAD_LAT, 32'h12345678};
    txn_tbl[4] = '{0, 1'b0, 32'h200, 32'h0000_0033, 3'b100, LOAD_LAT, 32'h12345678};
    txn_tbl[5] = '{0, 1'b1, 32'h104, 32'hCAFEF00D, 3'b001, STORE_LAT, 32'h0};
    txn_tbl[6] = '{1, 1'b0, 32'h104, 32'h0000_0044, 3'b101, LOAD_LAT, 32'hCAFEF00D};
    txn_tbl[7] = '{0, 1'b0, 32'h100, 32'h0000_0055, 3'b000, LOAD_LAT, 32'hDEADBEEF};

    rst = 1'b0;
    mem_clear = 1'b1;
    set_req(0, 1'b1, 1'b0, 32'd0, 32'd0, 3'd0);
    set_req(1, 1'b1, 1'b0, 32'd0, 32'd0, 3'd0);
    repeat (3) @(negedge clk);
    #1;
    check("reset_m0_ready", m0_req_ready, 1'b0);
    check("reset_m1_ready", m1_req_ready, 1'b0);
    check("reset_outputs", {busy, mem_en, mem_we, m0_rsp_valid, m1_rsp_valid}, 5'd0);
    check("reset_mem_bus", {mem_addr, mem_wdata, mem_funct3}, 67'd0);
    check("reset_rdata", {m0_rdata, m1_rdata}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    mem_clear = 1'b0;
    set_req(0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    set_req(1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);

    // Combinational ready in IDLE right after reset; valids drop before the edge so nothing is accepted.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      m0_req_valid = arb_tbl[i].m0_v;
      m1_req_valid = arb_tbl[i].m1_v;
      #1;
      check($sformatf("arb%0d_r0", i), m0_req_ready, arb_tbl[i].exp_r0);
      check($sformatf("arb%0d_r1", i), m1_req_ready, arb_tbl[i].exp_r1);
      #1;
      m0_req_valid = 1'b0;
      m1_req_valid = 1'b0;
    end

    for (int i = 0; i < 8; i++)
      do_txn(txn_tbl[i].port, txn_tbl[i].we, txn_tbl[i].addr, txn_tbl[i].wdata, txn_tbl[i].f3,
             txn_tbl[i].lat, txn_tbl[i].rdata, $sformatf("txn%0d", i));

    // Contention after reset: strict alternation starting with m0, next grant the cycle after RESP.
    apply_reset();
    run_contended(4);
    check("contend_count", cont_n, 4);
    for (int i = 0; i < 4 && i < cont_n; i++) begin
      check($sformatf("contend_owner%0d", i), cont_owner[i], i % 2);
      if (i > 0) check($sformatf("contend_gap%0d", i), cont_cyc[i] - cont_cyc[i-1], STORE_LAT + 1);
    end

    // m1 back-to-back loads; m0 arrives during WAIT and wins the next IDLE.
    @(negedge clk);
    set_req(1, 1'b1, 1'b0, 32'h200, 32'd0, 3'b010);
    #1;
    check("b2b_m1_first", m1_req_ready, 1'b1);
    @(negedge clk);
    set_req(1, 1'b1, 1'b0, 32'h100, 32'd0, 3'b010);
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 32'h180, 32'h55AA55AA, 3'b010);
    n_early = 0;
    for (int c = 2; c <= LOAD_LAT; c++) begin
      if (c > 2) @(negedge clk);
      #1;
      if (m0_req_ready || m1_req_ready) n_early++;
    end
    check("b2b_ready_while_busy", n_early, 0);
    @(negedge clk); #1;
    check("b2b_m0_wins", m0_req_ready, 1'b1);
    check("b2b_m1_waits", m1_req_ready, 1'b0);
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    k = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (m1_req_ready) break;
      @(negedge clk);
      k++;
    end
    check("b2b_m1_after_m0", k, 2);
    @(negedge clk);
    set_req(1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    wait_idle("b2b");

    // Reset asserted during a load's WAIT: outputs clear at once and the load never responds.
    @(negedge clk);
    set_req(1, 1'b1, 1'b0, 32'h200, 32'd0, 3'b010);
    #1;
    check("rstmid_accept", m1_req_ready, 1'b1);
    @(negedge clk);
    set_req(1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 32'h108, 32'h1, 3'b010);
    #2;
    rst = 1'b0;
    #1;
    check("rstmid_ctrl", {busy, mem_en, mem_we, m0_rsp_valid, m1_rsp_valid, m0_req_ready, m1_req_ready}, 7'd0);
    check("rstmid_mem_bus", {mem_addr, mem_wdata, mem_funct3}, 67'd0);
    check("rstmid_rdata", {m0_rdata, m1_rdata}, 64'd0);
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    @(negedge clk);
    rst = 1'b1;
    n_rsp = 0; n_busy = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk); #1;
      if (m0_rsp_valid || m1_rsp_valid) n_rsp++;
      if (busy) n_busy++;
    end
    check("rstmid_no_rsp", n_rsp, 0);
    check("rstmid_no_busy", n_busy, 0);
    do_txn(0, 1'b1, 32'h108, 32'h0BADF00D, 3'b010, STORE_LAT, 32'h0, "rstmid_next");

    apply_reset();
    run_random(600);

`ifdef DMEM_ARB_PERF_EN
    apply_reset();
    @(negedge clk); #1;
    check("perf_reset", conflict_cnt, 16'd0);
    run_contended(3);
    do_txn(0, 1'b1, 32'h110, 32'h1, 3'b010, STORE_LAT, 32'h0, "perf_solo0");
    do_txn(1, 1'b1, 32'h114, 32'h2, 3'b010, STORE_LAT, 32'h0, "perf_solo1");
    check("perf_count3", conflict_cnt, 16'd3);
    @(negedge clk);
    dut.conflict_q = 16'hFFFF;
    run_contended(1);
    check("perf_saturate", conflict_cnt, 16'hFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
